lfsr_prng: RTL and testbench

- Parametrised pseudo-random word generator for the GA datapath. Used for mutation masks, crossover points and selection indices.
- Runtime-selectable Fibonacci or Galois LFSR of WIDTH bits. Taps are programmable at runtime.
- Packs OUT_W freshly shifted bits into each output word; words never share bits. Words are delivered over a valid/ready handshake.
- Adds seed-load handshake, all-zero lockup detection and recovery, and backpressure.

---
 rtl/lfsr_prng.sv | 127 ++++++++++++
 tb/tb_lfsr_prng.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_prng.sv
// lfsr_prng: runtime-selectable Fibonacci/Galois LFSR that packs OUT_W
// freshly shifted bits into each word and hands it out over valid/ready.
// Supports seed loading, all-zero lockup recovery and backpressure.

// One combinational LFSR step. The output bit is always state[0];
// this block only produces the successor state.
module lfsr_prng_step #(
  parameter int WIDTH = 16
) (
  input  logic             mode,
  input  logic [WIDTH-1:0] taps,
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] nxt
);
  // Fibonacci shifts the tap parity in at the MSB; Galois folds taps in when the LSB is set
  always_comb begin
    nxt = state;
    if (mode) nxt = (state >> 1) ^ (state[0] ? taps : '0);
    else      nxt = {^(state & taps), state[WIDTH-1:1]};
  end
endmodule

module lfsr_prng #(
  parameter int               WIDTH        = 16,
  parameter int               OUT_W        = 8,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             MODE,
  input  logic [WIDTH-1:0] TAPS,
  input  logic             SEED_VALID,
  input  logic [WIDTH-1:0] SEED,
  input  logic             RAND_READY,
  output logic             RAND_VALID,
  output logic [OUT_W-1:0] RAND_OUT,
  output logic [WIDTH-1:0] STATE_OUT,
  output logic             LOCKUP
);
  localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(OUT_W - 1);

  typedef enum logic {FILL, HOLD} fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d, step_nxt;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OUT_W-1:0] word_q, word_d;
  logic             vld_q, vld_d;
  logic             lock_q, lock_d;

  lfsr_prng_step #(.WIDTH(WIDTH)) u_step (
    .mode  (MODE),
    .taps  (TAPS),
    .state (state_q),
    .nxt   (step_nxt)
  );

  // Register bank; async active-low reset restores the default seed and FILL
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fsm_q   <= FILL;
      state_q <= DEFAULT_SEED;
      cnt_q   <= '0;
      word_q  <= '0;
      vld_q   <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      vld_q   <= vld_d;
      lock_q  <= lock_d;
    end
  end

  // Next-state: seed load wins; FILL steps and collects a bit, HOLD waits for the handshake
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    vld_d   = vld_q;
    lock_d  = lock_q;
    if (SEED_VALID) begin
      // A zero seed would lock the register up, so it maps to the default
      state_d = (SEED == '0) ? DEFAULT_SEED : SEED;
      cnt_d   = '0;
      vld_d   = 1'b0;
      fsm_d   = FILL;
      lock_d  = 1'b0;
    end else begin
      case (fsm_q)
        FILL: begin
          if (state_q == '0) begin
            // Recover from lockup; no bit is taken and the counter holds
            state_d = DEFAULT_SEED;
            lock_d  = 1'b1;
          end else begin
            state_d        = step_nxt;
            word_d[cnt_q]  = state_q[0];
            if (cnt_q == CNT_LAST) begin
              cnt_d = '0;
              vld_d = 1'b1;
              fsm_d = HOLD;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (vld_q && RAND_READY) begin
            vld_d = 1'b0;
            fsm_d = FILL;
          end
        end
        default: fsm_d = FILL;
      endcase
    end
  end

  assign RAND_VALID = vld_q;
  assign RAND_OUT   = word_q;
  assign STATE_OUT  = state_q;
  assign LOCKUP     = lock_q;
endmodule

// File: tb/tb_lfsr_prng.sv
// Self-checking bench for lfsr_prng: a 16-bit default instance for reset and
// first-word latency, and a 4-bit instance for sequence, backpressure,
// lockup, seed-load and reset-in-HOLD scenarios. Expected words are queued
// when stimulus is applied and compared when the word is handed over.
module tb_lfsr_prng;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        rst16, rdy16, mode16, sv16;
  logic [15:0] taps16, seed16, st16;
  logic        v16, lk16;
  logic [7:0]  out16;

  // 4-bit instance
  logic        rst4, rdy4, m4, sv4;
  logic [3:0]  tp4, sd4, s4, o4;
  logic        v4, lk4;

  lfsr_prng u_dut16 (
    .CLK(clk), .RST(rst16), .MODE(mode16), .TAPS(taps16),
    .SEED_VALID(sv16), .SEED(seed16), .RAND_READY(rdy16),
    .RAND_VALID(v16), .RAND_OUT(out16), .STATE_OUT(st16), .LOCKUP(lk16)
  );

  lfsr_prng #(.WIDTH(4), .OUT_W(4), .DEFAULT_SEED(4'h9)) u_dut4 (
    .CLK(clk), .RST(rst4), .MODE(m4), .TAPS(tp4),
    .SEED_VALID(sv4), .SEED(sd4), .RAND_READY(rdy4),
    .RAND_VALID(v4), .RAND_OUT(o4), .STATE_OUT(s4), .LOCKUP(lk4)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Reference: n steps from s0 on a w-bit register, bit i of the word is the i-th output bit
  task automatic model_run(input logic [15:0] s0, input int w, input int n, input logic mode,
                           input logic [15:0] taps, output logic [31:0] word, output logic [15:0] s1);
    logic [15:0] s;
    logic b, fb;
    s = s0;
    word = '0;
    for (int i = 0; i < n; i++) begin
      b = s[0];
      word[i] = b;
      if (mode) s = (s >> 1) ^ (b ? taps : 16'h0);
      else begin
        fb = ^(s & taps);
        s = (s >> 1) | (16'(fb) << (w - 1));
      end
    end
    s1 = s;
  endtask

  task automatic seed_load4(input logic [3:0] v);
    @(posedge clk); #1;
    sv4 = 1'b1; sd4 = v;
    @(posedge clk); #1;
    sv4 = 1'b0; sd4 = 4'h0;
  endtask

  // One-cycle ready pulse; the delivered word is checked against the scoreboard
  task automatic take4();
    @(posedge clk); #1;
    rdy4 = 1'b1;
    @(negedge clk);
    chk("take_vld", v4, 1);
    if (v4) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) chk("word", o4, sb.pop_front());
    end
    @(posedge clk); #1;
    rdy4 = 1'b0;
  endtask

  // Edges until RAND_VALID, 0 on timeout
  task automatic wait_vld4(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); @(negedge clk);
      if (v4) begin n = i; break; end
    end
  endtask

  logic [3:0]  gs [4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1101};
  logic [3:0]  fs [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b1001};
  logic [31:0] w;
  logic [15:0] s;
  logic [3:0]  ob, bst;
  int          n;

  initial begin
    rst16 = 1'b0; rdy16 = 1'b1; mode16 = 1'b1; taps16 = 16'hB400; sv16 = 1'b0; seed16 = '0;
    rst4  = 1'b0; rdy4  = 1'b0; m4 = 1'b1; tp4 = 4'b1100; sv4 = 1'b0; sd4 = '0;
    #12;
    chk("r16_state", st16, 16'hACE1);
    chk("r16_vld",   v16, 0);
    chk("r16_out",   out16, 0);
    chk("r16_lock",  lk16, 0);
    chk("r4_state",  s4, 4'h9);

    @(posedge clk); #1;
    rst16 = 1'b1; rst4 = 1'b1;
    chk("rel16_state", st16, 16'hACE1);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); @(negedge clk);
      if (v16) begin n = i; break; end
    end
    chk("lat16", n, 8);
    model_run(16'hACE1, 16, 8, 1'b1, 16'hB400, w, s);
    chk("word16",  out16, w);
    chk("state16", st16, s);

    // Galois, taps 1100, seed 0001
    m4 = 1'b1; tp4 = 4'b1100;
    sb.push_back(32'h9); sb.push_back(32'h5);
    seed_load4(4'h1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      chk("g_state", s4, gs[i]);
    end
    chk("g_vld", v4, 1);
    take4();
    wait_vld4(n);
    chk("g_lat", n, 4);
    chk("g_state2", s4, 4'b0111);
    take4();

    // Fibonacci, taps 0011, seed 0001, then backpressure
    m4 = 1'b0; tp4 = 4'b0011;
    sb.push_back(32'h1);
    seed_load4(4'h1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      chk("f_state", s4, fs[i]);
    end
    chk("f_vld", v4, 1);
    ob = o4; bst = s4;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("bp_out",   o4, ob);
    chk("bp_state", s4, bst);
    chk("bp_vld",   v4, 1);
    model_run({12'h0, s4}, 4, 4, 1'b0, 16'h3, w, s);
    sb.push_back(w);
    take4();
    @(negedge clk);
    chk("bp_drop", v4, 0);
    wait_vld4(n);
    chk("bp_lat", n, 4);
    take4();

    // Lockup: taps 0 drains to zero, recovery reloads the default seed
    m4 = 1'b0; tp4 = 4'b0000;
    sb.push_back(32'h3);
    seed_load4(4'h1);
    @(posedge clk); @(negedge clk);
    chk("lk_zero",  s4, 4'h0);
    chk("lk_pre",   lk4, 0);
    @(posedge clk); @(negedge clk);
    chk("lk_state", s4, 4'h9);
    chk("lk_flag",  lk4, 1);
    chk("lk_vld",   v4, 0);
    wait_vld4(n);
    chk("lk_lat", n, 3);
    take4();
    seed_load4(4'h3);
    chk("ld_lock",  lk4, 0);
    chk("ld_state", s4, 4'h3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("lk2_flag",  lk4, 1);
    chk("lk2_state", s4, 4'h9);
    seed_load4(4'h0);
    chk("z_state", s4, 4'h9);
    chk("z_lock",  lk4, 0);
    chk("z_vld",   v4, 0);

    // Seed load after two collected bits discards the partial word
    m4 = 1'b1; tp4 = 4'b1100;
    seed_load4(4'h3);
    @(posedge clk);
    sb.push_back(32'h9);
    seed_load4(4'h1);
    chk("mf_vld", v4, 0);
    wait_vld4(n);
    chk("mf_lat", n, 4);
    take4();

    // Reset asserted while holding a word
    wait_vld4(n);
    chk("h_lat", n, 4);
    @(negedge clk); #2;
    rst4 = 1'b0;
    #1;
    chk("rh_state", s4, 4'h9);
    chk("rh_vld",   v4, 0);
    chk("rh_out",   o4, 0);
    chk("rh_lock",  lk4, 0);
    chk("sb_drain", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end
endmodule
